// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode helpers for the
// shared-ALU arbiter.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef logic [OP_W-1:0] alu_op_t;

  localparam alu_op_t OP_AND = 4'b0000;
  localparam alu_op_t OP_OR  = 4'b0001;
  localparam alu_op_t OP_XOR = 4'b0010;
  localparam alu_op_t OP_ADD = 4'b0011;
  localparam alu_op_t OP_SLT = 4'b0110;
  localparam alu_op_t OP_SUB = 4'b0111;
  localparam alu_op_t OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input alu_op_t op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SLT, OP_SUB, OP_NOR: legal = 1'b1;
      default:                                               legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Only ADD and SUB report carry-out and overflow
  function automatic logic is_arith_op(input alu_op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two requesters, the consumer and the
// shared-ALU arbiter.
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic             req0_valid;
  logic             req0_ready;
  alu_op_t          req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  alu_op_t          req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic             rsp_cout;
  logic             rsp_err;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_cout, rsp_err
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_cout, rsp_err
  );

endinterface

// File: rtl/alu32_core.sv
// Combinational ALU slice: AND/OR/XOR/ADD/SUB/SLT/NOR selected by
// {ainv, binv, op}; carry and overflow always reflect the adder.
module alu32_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ainv,
  input  logic             i_binv,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_cin_msb;
  logic             w_less;

  assign w_a = i_ainv ? ~i_a : i_a;
  assign w_b = i_binv ? ~i_b : i_b;

  // binv doubles as carry-in so SUB/SLT form a + ~b + 1
  assign {w_cout, w_sum} = {1'b0, w_a} + {1'b0, w_b} + (WIDTH+1)'(i_binv);

  assign w_cin_msb  = w_sum[WIDTH-1] ^ w_a[WIDTH-1] ^ w_b[WIDTH-1];
  assign o_cout     = w_cout;
  assign o_overflow = w_cin_msb ^ w_cout;
  assign w_less     = w_sum[WIDTH-1] ^ o_overflow;

  // op 2'b10 is XOR without binv and signed set-less-than with binv
  always_comb begin
    o_result = '0;
    case (i_op)
      2'b00:   o_result = w_a & w_b;
      2'b01:   o_result = w_a | w_b;
      2'b10:   o_result = i_binv ? {{(WIDTH-1){1'b0}}, w_less} : (w_a ^ w_b);
      default: o_result = w_sum;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters: grant in IDLE,
// evaluate in EXEC, hold the tagged result in RESP until the consumer takes it.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  alu_share_arbiter_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_ptr;
  logic             r_id;
  alu_op_t          r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_overflow;
  logic             r_rsp_cout;
  logic             r_rsp_err;

  logic             w_any_valid;
  logic             w_grant_id;
  logic             w_rsp_fire;
  logic             w_accept;
  logic             w_ready0;
  logic             w_ready1;

  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_cout;
  logic             w_alu_overflow;
  logic             w_legal;
  logic             w_arith;

  assign w_any_valid = bus.req0_valid | bus.req1_valid;
  // Pointer only breaks ties; a lone requester always wins
  assign w_grant_id  = (bus.req0_valid & bus.req1_valid) ? r_ptr : bus.req1_valid;
  assign w_rsp_fire  = r_rsp_valid & bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any_valid) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_fire) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    if (!reset && (r_state == ST_IDLE) && w_any_valid) begin
      w_accept = 1'b1;
      w_ready0 = ~w_grant_id;
      w_ready1 = w_grant_id;
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;

  alu32_core #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a        (r_a),
    .i_b        (r_b),
    .i_ainv     (r_op[3]),
    .i_binv     (r_op[2]),
    .i_op       (r_op[1:0]),
    .o_result   (w_alu_result),
    .o_cout     (w_alu_cout),
    .o_overflow (w_alu_overflow)
  );

  assign w_legal = is_legal_op(r_op);
  assign w_arith = is_arith_op(r_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr          <= 1'b0;
      r_id           <= 1'b0;
      r_op           <= OP_AND;
      r_a            <= '0;
      r_b            <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_zero     <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_cout     <= 1'b0;
      r_rsp_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_id  <= w_grant_id;
        r_ptr <= ~w_grant_id;
        r_op  <= w_grant_id ? bus.req1_op : bus.req0_op;
        r_a   <= w_grant_id ? bus.req1_a  : bus.req0_a;
        r_b   <= w_grant_id ? bus.req1_b  : bus.req0_b;
      end
      // Illegal opcodes report only err; every other field stays 0
      if (r_state == ST_EXEC) begin
        r_rsp_valid    <= 1'b1;
        r_rsp_id       <= r_id;
        r_rsp_err      <= ~w_legal;
        r_rsp_result   <= w_legal ? w_alu_result : '0;
        r_rsp_zero     <= w_legal && (w_alu_result == '0);
        r_rsp_overflow <= w_arith & w_alu_overflow;
        r_rsp_cout     <= w_arith & w_alu_cout;
      end else if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_id       = r_rsp_id;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_zero     = r_rsp_zero;
  assign bus.rsp_overflow = r_rsp_overflow;
  assign bus.rsp_cout     = r_rsp_cout;
  assign bus.rsp_err      = r_rsp_err;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one combinational 32-bit ALU datapath between two requesters. Each requester presents an operation (4-bit ALU control: ainv, binv, op[1:0]) and two operands over a valid/ready handshake. The block grants one request, registers the operands, evaluates the ALU for one cycle and holds a tagged result with flags until the consumer accepts it. It sits between the instruction-issue logic and the shared ALU.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 2.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid && ready.
- req0_op / req1_op  in  4  {ainv, binv, op[1:0]}.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- rsp_valid  out  1  result held.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  granted requester index.
- rsp_result  out  WIDTH  ALU result.
- rsp_zero  out  1  rsp_result == 0.
- rsp_overflow  out  1  signed overflow; ADD/SUB only, otherwise 0.
- rsp_cout  out  1  MSB carry-out; ADD/SUB only, otherwise 0.
- rsp_err  out  1  illegal opcode.

## Operation
- Legal codes: AND 0000; OR 0001; XOR 0010; ADD 0011; SLT 0110; SUB 0111; NOR 1100.
- SUB is a + ~b + 1.
- SLT gives result = {WIDTH-1 zeros, less}, where less = sum[MSB] ^ overflow of a − b. The comparison is signed.
- For SLT, rsp_overflow and rsp_cout are 0.
- Any other code gives result 0, rsp_err=1 and all other flags 0; it still completes a normal handshake.
- FSM states: IDLE, EXEC, RESP.
  - IDLE → EXEC when any req_valid is high. The grant takes a one-cycle ready pulse, and the operands, op and id are latched.
  - EXEC → RESP unconditionally. The ALU evaluates from the latched operands and the result and flags are registered.
  - RESP → IDLE on rsp_valid && rsp_ready.
- Arbitration uses a one-bit priority pointer that resets to 0.
  - If both requesters are valid in IDLE, the pointer holder is granted.
  - After any grant, the pointer is set to the other requester.
  - A single valid requester is always granted, whatever the pointer.
- req_ready is high only in IDLE, and only for the granted index. It is combinational from the req_valids and the pointer. It is never high for both requesters.
- Requests not granted must be held stable by the requester; no internal queue.

## Timing
- Reset values: state=IDLE, pointer=0, req0_ready=req1_ready=0 (during reset), rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_overflow=0, rsp_cout=0, rsp_err=0.
- Latency: accept at edge N; rsp_valid is high from cycle N+2.
- Peak throughput is one operation per 3 cycles with rsp_ready held high. The next acceptance can occur in the cycle after the response handshake.
- rsp_* outputs are registered and stable while rsp_valid && !rsp_ready (backpressure may last indefinitely).
- No request is accepted while in EXEC or RESP.
- Reset asserted in any state: the in-flight operation is discarded and the state is IDLE after that edge. rsp_valid is 0 from the next cycle and the pointer returns to 0.
- Arithmetic is modulo 2^WIDTH. Overflow = carry into MSB ^ carry out of MSB.

## Structure
- Shared package alu_pkg holds:
  - the 4-bit opcode constants (OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SLT, OP_SUB, OP_NOR);
  - the state enum (ST_IDLE, ST_EXEC, ST_RESP);
  - a function is_legal_op.
- One sub-module: alu32_core. It is purely combinational: inputs a, b, ainv, binv, op; outputs result, cout, overflow. It is instantiated once in the EXEC path.
- Arbitration, FSM and response registers live in alu_share_arbiter.

## Test plan
- Single ADD: req0 ADD a=0x7FFFFFFF, b=1 → rsp at N+2: result=0x80000000, overflow=1, cout=0, zero=0, id=0.
- SUB and SLT:
  - req1 SUB a=5, b=5 → result=0, zero=1, cout=1, id=1.
  - SLT a=0xFFFFFFFF, b=1 → result=1.
  - SLT a=0x80000000, b=0x7FFFFFFF → result=1.
- Round robin:
  - both requesters valid continuously → grants alternate 0,1,0,1 from reset, with ready never high on both.
  - then req1 alone twice → granted twice.
- Backpressure: rsp_ready low for 10 cycles after NOR a=0, b=0 → rsp_valid held, result=0xFFFFFFFF stable, both req_ready=0 throughout.
- Illegal op 0101 with a=3, b=4 → result=0, err=1, overflow=cout=0. The next legal request is serviced normally.
- Reset in EXEC, then reset in RESP → rsp_valid=0 the cycle after reset, pointer=0, and the next dual request is granted to requester 0.
